// File: rtl/exe_status_stage.sv
// Purpose : EXE back end - NZCV status register, ID condition check against forwarded flags, EXE/MEM register.
// Latency : 1 cycle EXE->MEM and Status_Bits->SR; Cond_Pass is combinational (0 cycles).
// Backpr. : Freeze holds every register; Flush/~Exe_Valid bubble the MEM control bits and block SR writes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Freeze, Flush         memory-stage stall / kill of the EXE instruction
//   Exe_Valid, S          EXE holds a real instruction / it sets flags
//   Status_Bits[3:0]      ALU flags {N,Z,C,V}
//   Alu_Res, Val_Rm[31:0] ALU result / store data
//   Dest[3:0]             destination register
//   WB_EN, MEM_R_EN, MEM_W_EN  EXE control bits
//   Cond[3:0]             condition field of the instruction in ID
//   SR[3:0], Carry_Out    architectural flags and registered carry for the ALU
//   Cond_Pass             ID instruction's condition holds
//   *_Mem                 EXE/MEM pipeline register outputs
module exe_status_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        Freeze,
   input  logic        Flush,
   input  logic        Exe_Valid,
   input  logic        S,
   input  logic [3:0]  Status_Bits,
   input  logic [31:0] Alu_Res,
   input  logic [31:0] Val_Rm,
   input  logic [3:0]  Dest,
   input  logic        WB_EN,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [3:0]  Cond,
   output logic [3:0]  SR,
   output logic        Carry_Out,
   output logic        Cond_Pass,
   output logic [31:0] Alu_Res_Mem,
   output logic [31:0] Val_Rm_Mem,
   output logic [3:0]  Dest_Mem,
   output logic        WB_EN_Mem,
   output logic        MEM_R_EN_Mem,
   output logic        MEM_W_EN_Mem
);

   logic       sr_we;
   logic [3:0] sr_next;
   logic       n_f, z_f, c_f, v_f;

   assign sr_we   = S & Exe_Valid & ~Flush & ~Freeze;
   assign sr_next = sr_we ? Status_Bits : SR;

   always_ff @(posedge clk) begin
      if (rst) SR <= 4'b0000;
      else     SR <= sr_next;
   end

   // ADC/SBC must see the flags as of instruction start, so no forwarding here.
   assign Carry_Out = SR[1];

   // Condition is judged on the forwarded flags so a flag-setting instruction
   // in EXE conditions its successor in ID without a stall.
   assign n_f = sr_next[3];
   assign z_f = sr_next[2];
   assign c_f = sr_next[1];
   assign v_f = sr_next[0];

   always_comb begin
      Cond_Pass = 1'b0;
      case (Cond)
         4'b0000: Cond_Pass = z_f;
         4'b0001: Cond_Pass = ~z_f;
         4'b0010: Cond_Pass = c_f;
         4'b0011: Cond_Pass = ~c_f;
         4'b0100: Cond_Pass = n_f;
         4'b0101: Cond_Pass = ~n_f;
         4'b0110: Cond_Pass = v_f;
         4'b0111: Cond_Pass = ~v_f;
         4'b1000: Cond_Pass = c_f & ~z_f;
         4'b1001: Cond_Pass = ~c_f | z_f;
         4'b1010: Cond_Pass = (n_f == v_f);
         4'b1011: Cond_Pass = (n_f != v_f);
         4'b1100: Cond_Pass = ~z_f & (n_f == v_f);
         4'b1101: Cond_Pass = z_f | (n_f != v_f);
         4'b1110: Cond_Pass = 1'b1;
         default: Cond_Pass = 1'b0;   // reserved encoding never executes
      endcase
   end

   // EXE/MEM register. A killed or empty slot still carries its data fields;
   // only the control bits are cleared so MEM/WB do nothing with them.
   always_ff @(posedge clk) begin
      if (rst) begin
         Alu_Res_Mem  <= 32'd0;
         Val_Rm_Mem   <= 32'd0;
         Dest_Mem     <= 4'd0;
         WB_EN_Mem    <= 1'b0;
         MEM_R_EN_Mem <= 1'b0;
         MEM_W_EN_Mem <= 1'b0;
      end else if (!Freeze) begin
         Alu_Res_Mem <= Alu_Res;
         Val_Rm_Mem  <= Val_Rm;
         Dest_Mem    <= Dest;
         if (Flush || !Exe_Valid) begin
            WB_EN_Mem    <= 1'b0;
            MEM_R_EN_Mem <= 1'b0;
            MEM_W_EN_Mem <= 1'b0;
         end else begin
            WB_EN_Mem    <= WB_EN;
            MEM_R_EN_Mem <= MEM_R_EN;
            MEM_W_EN_Mem <= MEM_W_EN;
         end
      end
   end

endmodule

// File: tb/tb_exe_status_stage.sv
// Purpose : scoreboard bench for exe_status_stage; directed plan followed by random traffic.
// Latency : expects Cond_Pass in the drive cycle and registered outputs one edge later.
// Backpr. : none; one stimulus vector per cycle, monitors pop one expectation per cycle.
module tb_exe_status_stage;

   logic        clk = 1'b0;
   logic        rst, Freeze, Flush, Exe_Valid, S;
   logic [3:0]  Status_Bits, Dest, Cond;
   logic [31:0] Alu_Res, Val_Rm;
   logic        WB_EN, MEM_R_EN, MEM_W_EN;
   logic [3:0]  SR;
   logic        Carry_Out, Cond_Pass;
   logic [31:0] Alu_Res_Mem, Val_Rm_Mem;
   logic [3:0]  Dest_Mem;
   logic        WB_EN_Mem, MEM_R_EN_Mem, MEM_W_EN_Mem;

   always #5 clk = ~clk;

   exe_status_stage dut (
      .clk(clk), .rst(rst), .Freeze(Freeze), .Flush(Flush), .Exe_Valid(Exe_Valid), .S(S),
      .Status_Bits(Status_Bits), .Alu_Res(Alu_Res), .Val_Rm(Val_Rm), .Dest(Dest),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .Cond(Cond),
      .SR(SR), .Carry_Out(Carry_Out), .Cond_Pass(Cond_Pass),
      .Alu_Res_Mem(Alu_Res_Mem), .Val_Rm_Mem(Val_Rm_Mem), .Dest_Mem(Dest_Mem),
      .WB_EN_Mem(WB_EN_Mem), .MEM_R_EN_Mem(MEM_R_EN_Mem), .MEM_W_EN_Mem(MEM_W_EN_Mem)
   );

   typedef struct {
      logic        rst, fz, fl, v, s;
      logic [3:0]  sb, dest, cond;
      logic [31:0] ar, rm;
      logic        wb, mr, mw;
   } stim_t;

   typedef struct packed {
      logic [3:0]  sr;
      logic [31:0] ar, rm;
      logic [3:0]  dest;
      logic        wb, mr, mw;
   } regs_t;

   int     n_vec  = 0;
   int     n_fail = 0;
   logic   cp_q[$];
   regs_t  reg_q[$];
   regs_t  m;             // model of the state after the most recent edge
   bit     m_known = 0;   // SR is undefined until the first reset edge

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Condition rules as pairs: odd encodings are the negation of the even one
   // below them; the pair 111x is "always"/"never".
   function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c >> 1)
         0: base = z;
         1: base = cy;
         2: base = n;
         3: base = v;
         4: base = cy && !z;
         5: base = (n == v);
         6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic stim_t idle();
      stim_t t;
      t.rst = 0; t.fz = 0; t.fl = 0; t.v = 0; t.s = 0;
      t.sb = 0; t.dest = 0; t.cond = 4'b1110; t.ar = 0; t.rm = 0;
      t.wb = 0; t.mr = 0; t.mw = 0;
      return t;
   endfunction

   task automatic step(input stim_t t);
      logic [3:0] flags;
      @(negedge clk);
      rst = t.rst; Freeze = t.fz; Flush = t.fl; Exe_Valid = t.v; S = t.s;
      Status_Bits = t.sb; Alu_Res = t.ar; Val_Rm = t.rm; Dest = t.dest;
      WB_EN = t.wb; MEM_R_EN = t.mr; MEM_W_EN = t.mw; Cond = t.cond;
      // Flags visible this cycle: the EXE instruction's new flags if it commits them.
      flags = (t.s && t.v && !t.fl && !t.fz) ? t.sb : m.sr;
      if (m_known) cp_q.push_back(cond_model(t.cond, flags));
      if (t.rst) begin
         m = '0;
         m_known = 1;
      end else if (!t.fz) begin
         m.sr = flags;
         m.ar = t.ar; m.rm = t.rm; m.dest = t.dest;
         if (t.fl || !t.v) {m.wb, m.mr, m.mw} = 3'b000;
         else              {m.wb, m.mr, m.mw} = {t.wb, t.mr, t.mw};
      end
      reg_q.push_back(m);
   endtask

   // Combinational output monitor: mid low phase, inputs settled.
   initial forever begin
      @(negedge clk);
      #2;
      if (cp_q.size() > 0) chk("Cond_Pass", {31'd0, Cond_Pass}, {31'd0, cp_q.pop_front()});
   end

   // Registered output monitor: just after each rising edge.
   initial forever begin
      regs_t e;
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         chk("SR",           {28'd0, SR},           {28'd0, e.sr});
         chk("Carry_Out",    {31'd0, Carry_Out},    {31'd0, e.sr[1]});
         chk("Alu_Res_Mem",  Alu_Res_Mem,           e.ar);
         chk("Val_Rm_Mem",   Val_Rm_Mem,            e.rm);
         chk("Dest_Mem",     {28'd0, Dest_Mem},     {28'd0, e.dest});
         chk("WB_EN_Mem",    {31'd0, WB_EN_Mem},    {31'd0, e.wb});
         chk("MEM_R_EN_Mem", {31'd0, MEM_R_EN_Mem}, {31'd0, e.mr});
         chk("MEM_W_EN_Mem", {31'd0, MEM_W_EN_Mem}, {31'd0, e.mw});
      end
   end

   initial begin
      stim_t t;
      m = '0;
      rst = 1; Freeze = 0; Flush = 0; Exe_Valid = 0; S = 0; Status_Bits = 0;
      Alu_Res = 0; Val_Rm = 0; Dest = 0; WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; Cond = 0;

      // Reset, then NE / EQ / AL against a cleared SR.
      t = idle(); t.rst = 1; step(t);
      t = idle(); t.rst = 1; t.cond = 4'b0001; step(t);
      t = idle(); t.cond = 4'b0001; step(t);
      t = idle(); t.cond = 4'b0000; step(t);
      t = idle(); t.cond = 4'b1110; step(t);

      // Forwarded Z conditions EQ in the same cycle; SR follows next edge.
      t = idle(); t.s = 1; t.v = 1; t.sb = 4'b0100; t.cond = 4'b0000; step(t);
      t = idle(); t.cond = 4'b0000; step(t);

      // Three frozen cycles hold everything; carry lands on the first free edge.
      for (int i = 0; i < 3; i++) begin
         t = idle(); t.s = 1; t.v = 1; t.sb = 4'b0010; t.fz = 1;
         t.ar = 32'hA5A5_0000 + i; t.wb = 1; t.cond = 4'b0010; step(t);
      end
      t = idle(); t.s = 1; t.v = 1; t.sb = 4'b0010; t.cond = 4'b0010; step(t);
      t = idle(); t.cond = 4'b0010; step(t);

      // Flushed S-instruction: data passes, control and SR do not.
      t = idle(); t.s = 1; t.v = 1; t.fl = 1; t.sb = 4'b1111; t.ar = 32'h0000_00FF;
      t.dest = 4'd5; t.wb = 1; t.mr = 1; step(t);
      // Freeze and Flush together: register holds.
      t = idle(); t.v = 1; t.fz = 1; t.fl = 1; t.ar = 32'h1234_5678; t.wb = 1; step(t);

      // SR = 1001: GE, LT, GT, HI, reserved.
      t = idle(); t.s = 1; t.v = 1; t.sb = 4'b1001; t.cond = 4'b1010; step(t);
      foreach (t.cond[i]) begin end
      begin
         logic [3:0] conds [5] = '{4'b1010, 4'b1011, 4'b1100, 4'b1000, 4'b1111};
         for (int i = 0; i < 5; i++) begin
            t = idle(); t.cond = conds[i]; step(t);
         end
      end

      // Reset on the same edge as a flag write, and under Freeze.
      t = idle(); t.s = 1; t.v = 1; t.sb = 4'b1111; t.rst = 1; t.wb = 1; t.ar = 32'hFFFF_FFFF; step(t);
      t = idle(); t.v = 1; t.wb = 1; t.mw = 1; t.rm = 32'hDEAD_BEEF; t.dest = 4'd9; step(t);
      t = idle(); t.fz = 1; t.rst = 1; step(t);

      // Random traffic, including back-to-back S-instructions.
      for (int i = 0; i < 600; i++) begin
         t.rst  = ($urandom_range(0, 49) == 0);
         t.fz   = ($urandom_range(0, 4) == 0);
         t.fl   = ($urandom_range(0, 5) == 0);
         t.v    = ($urandom_range(0, 5) != 0);
         t.s    = ($urandom_range(0, 2) != 0);
         t.sb   = 4'($urandom);
         t.ar   = $urandom;
         t.rm   = $urandom;
         t.dest = 4'($urandom);
         t.wb   = 1'($urandom);
         t.mr   = 1'($urandom);
         t.mw   = 1'($urandom);
         t.cond = 4'($urandom);
         step(t);
      end

      // Let the monitors drain the final expectations, then confirm nothing was left.
      @(posedge clk);
      #3;
      chk("queues_drained", cp_q.size() + reg_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_status_stage.md
# exe_status_stage

EXE-stage back end: holds the architectural NZCV status register, returns the carry flag to the ALU, and evaluates the ARM condition field for the instruction in ID. It forwards the flags the ALU is producing in the current cycle. It also provides the EXE/MEM pipeline register that captures the ALU result and control bits for the memory stage. It sits directly downstream of the ALU and consumes `Alu_Res` and `Status_Bits`.

## Interface
- No parameters. Widths are fixed: 32-bit data, 4-bit register index, 4-bit NZCV.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Freeze` in 1: memory-stage stall. All state holds.
- `Flush` in 1: kills the instruction currently in EXE.
- `Exe_Valid` in 1: the EXE stage holds a real instruction.
- `S` in 1: the EXE instruction updates flags.
- `Status_Bits` in 4: ALU flags. Bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
- `Alu_Res` in 32: ALU result.
- `Val_Rm` in 32: store data.
- `Dest` in 4: destination register.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN` in 1 each: EXE control bits.
- `Cond` in 4: condition field of the instruction in ID.
- `SR` out 4: status register, NZCV.
- `Carry_Out` out 1: `SR[1]`. Wired to the ALU `Carry_In`.
- `Cond_Pass` out 1: the ID instruction's condition holds.
- `Alu_Res_Mem`, `Val_Rm_Mem` out 32 each: registered to MEM.
- `Dest_Mem` out 4: registered to MEM.
- `WB_EN_Mem`, `MEM_R_EN_Mem`, `MEM_W_EN_Mem` out 1 each: registered to MEM.

## Operation
- Internal signal `sr_we = S & Exe_Valid & ~Flush & ~Freeze`.
- `SR_next = sr_we ? Status_Bits : SR`.
- Rising-edge priority for `SR`: `rst` gives 0000; otherwise `SR <= SR_next`.
- Rising-edge priority for the EXE/MEM register:
  - `rst`: all outputs 0.
  - else `Freeze`: hold all fields.
  - else `Flush` or `~Exe_Valid`: the three control bits become 0. Data fields (`Alu_Res_Mem`, `Val_Rm_Mem`, `Dest_Mem`) still load the inputs.
  - else: load every field from its input.
- `Cond_Pass` is combinational and evaluated against `SR_next`. An S-instruction in EXE therefore conditions the instruction behind it in the same cycle, with no stall.
- Condition decode, with N, Z, C, V taken from `SR_next`:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C & ~Z. 1001 LS: ~C | Z.
  - 1010 GE: N == V. 1011 LT: N != V.
  - 1100 GT: ~Z & (N == V). 1101 LE: Z | (N != V).
  - 1110 AL: 1. 1111: 0 (reserved, never executes).
- `Carry_Out = SR[1]`, registered value only. ADC/SBC read the flags as of instruction start.
- No arithmetic is performed. All fields are pass-through widths with no truncation.

## Timing
- Reset value of every output: `SR` = 0000, all `*_Mem` = 0, `Carry_Out` = 0. `Cond_Pass` after reset equals the decode of 0000: EQ gives 0, NE gives 1, AL gives 1.
- EXE to MEM latency is 1 cycle. Flags reach `SR` 1 cycle after `sr_we`.
- `Cond_Pass` has zero-cycle latency from `Cond`, `Status_Bits`, `S`, `Exe_Valid`, `Flush` and `Freeze`.
- `Freeze` and `Flush` high together: `Freeze` wins for the pipeline register. `SR` is still blocked by `Flush` and `Freeze`.
- A `Freeze` lasting N cycles holds every output for N cycles. The flagged instruction updates `SR` on the first unfrozen edge only, exactly once.
- `rst` asserted mid-operation: the next edge clears everything regardless of `Freeze`.
- Back-to-back S-instructions: each one's flags become visible to its successor via `SR_next`.

## Test plan
- Reset, then `Cond`=0001 (NE) -> `SR`=0000, `Cond_Pass`=1. `Cond`=0000 (EQ) -> `Cond_Pass`=0. All `*_Mem`=0.
- `S`=1, `Exe_Valid`=1, `Status_Bits`=0100, `Cond`=0000 -> `Cond_Pass`=1 in the same cycle; next cycle `SR`=0100.
- `S`=1, `Status_Bits`=0010, `Freeze`=1 for 3 cycles -> `SR` and `*_Mem` unchanged for 3 edges; `SR`=0010 after `Freeze` drops; `Carry_Out`=1.
- `Alu_Res`=0x0000_00FF, `Dest`=5, `WB_EN`=1, `Flush`=1, `S`=1 -> `Alu_Res_Mem`=0xFF, `WB_EN_Mem`=0, `SR` unchanged.
- `SR`=1001 (N=1, V=1): GE gives 1, LT gives 0, GT gives 1, HI gives 0, condition 1111 gives 0.
- `S`=1, `Status_Bits`=1111, `rst` asserted on the same edge -> `SR`=0000, all `*_Mem`=0.
